// File: rtl/sm_regdump_if.sv
`default_nettype none
// ============================================================================
// Module   : sm_regdump_if
// Brief    : Bundle of the register-dump engine's control, debug-read and
//            byte-stream signals. The master side is the dump engine.
// Revision : 1.0 - initial release
// ============================================================================
interface sm_regdump_if;
    logic        start;      // frame request
    logic        mode_cont;  // back-to-back frames when set
    logic [3:0]  regAddr;    // debug read address
    logic [31:0] regData;    // debug read data, combinational from regAddr
    logic [7:0]  tx_data;    // byte toward the sink
    logic        tx_valid;   // tx_data is valid
    logic        tx_ready;   // sink accepts the byte
    logic        busy;       // frame in progress
    logic        done;       // end-of-frame pulse

    modport master (
        input  start, mode_cont, regData, tx_ready,
        output regAddr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, mode_cont, regData, tx_ready,
        input  regAddr, tx_data, tx_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sm_regdump.sv
`default_nettype none
// ============================================================================
// Module   : sm_regdump
// Brief    : Walks r0..r(NUM_REGS-1) through the debug read port and streams
//            a frame (header, register bytes MSB-first, XOR checksum) over a
//            valid/ready byte interface. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module sm_regdump #(
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_p,
    sm_regdump_if.master  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] c_LAST_IDX = 4'(NUM_REGS - 1);

    logic [2:0]  r_state,    w_state_nxt;
    logic [3:0]  r_addr,     w_addr_nxt;
    logic [3:0]  r_index,    w_index_nxt;
    logic [1:0]  r_bcnt,     w_bcnt_nxt;
    logic [7:0]  r_csum,     w_csum_nxt;
    logic [23:0] r_shift,    w_shift_nxt;   // low three bytes still to send
    logic [7:0]  r_tx_data,  w_tx_data_nxt;
    logic        r_tx_valid, w_tx_valid_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_done,     w_done_nxt;
    logic        w_launch;
    logic        w_xfer;

    assign w_xfer = r_tx_valid & bus.tx_ready;

    // Next-state and output computation; every register holds by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_index_nxt    = r_index;
        w_bcnt_nxt     = r_bcnt;
        w_csum_nxt     = r_csum;
        w_shift_nxt    = r_shift;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_launch       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) w_launch = 1'b1;
            end
            S_HDR: begin
                // Header goes out unchecksummed.
                if (w_xfer) begin
                    w_state_nxt    = S_SETUP;
                    w_tx_valid_nxt = 1'b0;
                end
            end
            S_SETUP: begin
                // regAddr has been stable all cycle; capture the word now.
                w_shift_nxt    = bus.regData[23:0];
                w_tx_data_nxt  = bus.regData[31:24];
                w_tx_valid_nxt = 1'b1;
                w_bcnt_nxt     = 2'd0;
                w_state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_csum_nxt = r_csum ^ r_tx_data;
                    if (r_bcnt == 2'd3) begin
                        if (r_index == c_LAST_IDX) begin
                            w_state_nxt   = S_CHK;
                            w_tx_data_nxt = r_csum ^ r_tx_data;
                        end else begin
                            w_index_nxt    = r_index + 4'd1;
                            w_addr_nxt     = r_index + 4'd1;
                            w_tx_valid_nxt = 1'b0;
                            w_state_nxt    = S_SETUP;
                        end
                    end else begin
                        w_bcnt_nxt    = r_bcnt + 2'd1;
                        w_tx_data_nxt = r_shift[23:16];
                        w_shift_nxt   = {r_shift[15:0], 8'h00};
                    end
                end
            end
            S_CHK: begin
                if (w_xfer) begin
                    w_state_nxt    = S_DONE;
                    w_tx_valid_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.mode_cont) w_launch = 1'b1;
                else               w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A new frame from IDLE or a continuous restart from DONE is identical.
        if (w_launch) begin
            w_state_nxt    = S_HDR;
            w_tx_data_nxt  = HEADER;
            w_tx_valid_nxt = 1'b1;
            w_busy_nxt     = 1'b1;
            w_index_nxt    = 4'd0;
            w_addr_nxt     = 4'd0;
            w_csum_nxt     = 8'h00;
        end
    end

    // State and output registers with synchronous reset that abandons any frame.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state    <= S_IDLE;
            r_addr     <= 4'd0;
            r_index    <= 4'd0;
            r_bcnt     <= 2'd0;
            r_csum     <= 8'h00;
            r_shift    <= 24'h0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_index    <= w_index_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_csum     <= w_csum_nxt;
            r_shift    <= w_shift_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.regAddr  = r_addr;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sm_regdump.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_regdump
// Brief    : Self-checking bench for sm_regdump with a behavioural frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_regdump;

    localparam int c_N = 16;

    logic clk = 1'b0;
    logic rst_p;

    sm_regdump_if bus ();

    logic [31:0] regs [c_N];
    assign bus.regData = regs[bus.regAddr];

    sm_regdump #(.NUM_REGS(c_N), .HEADER(8'hA5)) dut (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    logic [3:0]  addr_seq [$];
    int          busy_cycles;
    int          done_cycles;

    // One comparison: counts and reports a mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_vec++;
        assert (obs === expd) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    // Reference frame: header, each register MSB-first, XOR of register bytes.
    task automatic build_expected();
        logic [7:0] cs;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int r = 0; r < c_N; r++) begin
            for (int k = 3; k >= 0; k--) begin
                b = 8'((regs[r] >> (8 * k)) & 32'hFF);
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] g;
        build_expected();
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, g}, {24'h0, exp_q[i]});
        end
    endtask

    task automatic kick();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Drives tx_ready cycle by cycle and records the byte stream until done.
    // rdy_mode 0: always ready, 1: random, 2: stall 5 cycles at byte stall_at.
    task automatic collect(input int rdy_mode, input int stall_at, input int inj_at);
        int         cyc = 0;
        int         stalls = 0;
        bit         seen_done = 1'b0;
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pd = 8'h00;
        got.delete();
        addr_seq.delete();
        busy_cycles = 0;
        done_cycles = 0;
        addr_seq.push_back(bus.regAddr);
        while (!seen_done && cyc < 3000) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                done_cycles++;
                seen_done = 1'b1;
            end
            if (bus.regAddr != addr_seq[$]) addr_seq.push_back(bus.regAddr);
            if (pv && !pr) begin
                chk("hold_valid", {31'h0, bus.tx_valid}, 32'd1);
                chk("hold_data", {24'h0, bus.tx_data}, {24'h0, pd});
            end
            if (rdy_mode == 1)
                bus.tx_ready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 2 && got.size() == stall_at && stalls < 5) begin
                bus.tx_ready = 1'b0;
                stalls++;
            end else
                bus.tx_ready = 1'b1;
            bus.start = (cyc == inj_at);
            if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
            pv = bus.tx_valid;
            pr = bus.tx_ready;
            pd = bus.tx_data;
            cyc++;
            @(posedge clk); #1;
        end
        bus.start    = 1'b0;
        bus.tx_ready = 1'b1;
        chk("frame_timeout", {31'h0, seen_done}, 32'd1);
    endtask

    task automatic rand_regs();
        for (int i = 0; i < c_N; i++) regs[i] = $urandom();
    endtask

    initial begin
        rst_p         = 1'b1;
        bus.start     = 1'b0;
        bus.mode_cont = 1'b0;
        bus.tx_ready  = 1'b1;
        for (int i = 0; i < c_N; i++) regs[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_p = 1'b0;

        // Reset state
        chk("rst_valid", {31'h0, bus.tx_valid}, 32'd0);
        chk("rst_busy",  {31'h0, bus.busy},     32'd0);
        chk("rst_done",  {31'h0, bus.done},     32'd0);
        chk("rst_addr",  {28'h0, bus.regAddr},  32'd0);
        chk("rst_data",  {24'h0, bus.tx_data},  32'd0);

        // Incrementing pattern, ready tied high: bytes, timing, address walk
        for (int i = 0; i < c_N; i++) regs[i] = 32'h11111111 * i;
        kick();
        collect(0, -1, -1);
        check_frame("inc");
        chk("inc_busy_cycles", 32'(busy_cycles), 32'd82);
        chk("inc_done_cycles", 32'(done_cycles), 32'd1);
        chk("inc_done_after", {31'h0, bus.done}, 32'd0);
        chk("inc_addr_len", 32'(addr_seq.size()), 32'(c_N));
        for (int i = 0; i < c_N; i++)
            chk($sformatf("inc_addr%0d", i),
                (i < addr_seq.size()) ? {28'h0, addr_seq[i]} : 32'hxxxxxxxx, 32'(i));

        // Single non-zero register
        for (int i = 0; i < c_N; i++) regs[i] = 32'h0;
        regs[1] = 32'h12345678;
        kick();
        collect(0, -1, -1);
        check_frame("r1");
        chk("r1_b5",  {24'h0, got[5]},  32'h12);
        chk("r1_b6",  {24'h0, got[6]},  32'h34);
        chk("r1_b7",  {24'h0, got[7]},  32'h56);
        chk("r1_b8",  {24'h0, got[8]},  32'h78);
        chk("r1_chk", {24'h0, got[65]}, 32'h08);

        // Stall on the header, then on the 3rd byte of r3
        rand_regs();
        kick();
        collect(2, 0, -1);
        check_frame("stall_hdr");
        rand_regs();
        kick();
        collect(2, 1 + 4 * 3 + 2, -1);
        check_frame("stall_mid");

        // Random backpressure
        rand_regs();
        kick();
        collect(1, -1, -1);
        check_frame("rand_rdy");

        // Start while busy is ignored
        rand_regs();
        kick();
        collect(0, -1, 20);
        check_frame("start_busy");
        chk("start_busy_done_cycles", 32'(done_cycles), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("start_busy_idle_valid", {31'h0, bus.tx_valid}, 32'd0);
            chk("start_busy_idle_busy",  {31'h0, bus.busy},     32'd0);
            @(posedge clk); #1;
        end

        // Continuous mode: header right after done, checksum restarts
        rand_regs();
        bus.mode_cont = 1'b1;
        kick();
        collect(0, -1, -1);
        check_frame("cont1");
        chk("cont_hdr_valid", {31'h0, bus.tx_valid}, 32'd1);
        chk("cont_hdr_data",  {24'h0, bus.tx_data},  32'hA5);
        chk("cont_hdr_busy",  {31'h0, bus.busy},     32'd1);
        rand_regs();
        bus.mode_cont = 1'b0;
        collect(0, -1, -1);
        check_frame("cont2");
        chk("cont2_busy_cycles", 32'(busy_cycles), 32'd82);

        // Reset during SEND of r7, then a clean frame
        rand_regs();
        kick();
        repeat (38) begin
            @(posedge clk); #1;
        end
        chk("mid_addr", {28'h0, bus.regAddr}, 32'd7);
        chk("mid_busy", {31'h0, bus.busy},    32'd1);
        rst_p = 1'b1;
        @(posedge clk); #1;
        rst_p = 1'b0;
        chk("mrst_valid", {31'h0, bus.tx_valid}, 32'd0);
        chk("mrst_busy",  {31'h0, bus.busy},     32'd0);
        chk("mrst_addr",  {28'h0, bus.regAddr},  32'd0);
        chk("mrst_done",  {31'h0, bus.done},     32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mrst_idle_valid", {31'h0, bus.tx_valid}, 32'd0);
        rand_regs();
        kick();
        collect(0, -1, -1);
        check_frame("after_rst");
        chk("after_rst_busy_cycles", 32'(busy_cycles), 32'd82);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
